// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar response path: data width,
// command encodings and the {master, cmd} tag carried per request.
package xbar_pkg;

  localparam int DATA_W = 32;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef struct packed {
    logic master;
    logic cmd;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/tag_fifo.sv
// In-order tag FIFO with show-ahead read; the caller guarantees it never
// pushes into a full FIFO without a same-cycle pop, nor pops when empty.
module tag_fifo #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [TAG_W-1:0]         i_wtag,
  output logic [TAG_W-1:0]         o_rtag,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [TAG_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wtag;
  end

  assign o_rtag  = r_mem[r_rptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/xbar_resp_router.sv
// Per-slave response router: remembers who issued each request and steers
// the in-order slave responses back to master 0 or master 1.
module xbar_resp_router
  import xbar_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = xbar_pkg::DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_fire,
  input  logic                    req_master,
  input  logic                    req_cmd,
  input  logic                    slave_resp,
  input  logic [DATA_W-1:0]       slave_rdata,
  output logic                    resp0,
  output logic                    resp1,
  output logic [DATA_W-1:0]       rdata0,
  output logic [DATA_W-1:0]       rdata1,
  output logic                    stall,
  output logic [$clog2(DEPTH):0]  outstanding,
  output logic                    proto_err
);

  tag_t                   w_new_tag;
  tag_t                   w_head;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_pop_ok;
  logic                   w_push_ok;
  logic                   w_drop;
  logic [DATA_W-1:0]      w_resp_data;

  logic                   r_resp0;
  logic                   r_resp1;
  logic [DATA_W-1:0]      r_rdata0;
  logic [DATA_W-1:0]      r_rdata1;
  logic                   r_proto_err;

  assign w_new_tag.master = req_master;
  assign w_new_tag.cmd    = req_cmd;

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign w_pop_ok  = slave_resp & ~w_empty;
  assign w_push_ok = req_fire & (~w_full | w_pop_ok);
  assign w_drop    = (req_fire & w_full & ~w_pop_ok) | (slave_resp & w_empty);

  assign w_resp_data = (w_head.cmd == CMD_READ) ? slave_rdata : '0;

  tag_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_ok),
    .i_pop   (w_pop_ok),
    .i_wtag  (w_new_tag),
    .o_rtag  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp0     <= 1'b0;
      r_resp1     <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_resp0 <= w_pop_ok & ~w_head.master;
      r_resp1 <= w_pop_ok &  w_head.master;
      if (w_pop_ok) begin
        if (w_head.master) r_rdata1 <= w_resp_data;
        else               r_rdata0 <= w_resp_data;
      end
      if (w_drop) r_proto_err <= 1'b1;
    end
  end

  assign resp0       = r_resp0;
  assign resp1       = r_resp1;
  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;
  assign proto_err   = r_proto_err;
  assign outstanding = w_count;
  assign stall       = w_full;

endmodule

// File: tb/tb_xbar_resp_router.sv
// Directed bench for xbar_resp_router: routing order, full/empty handling,
// pointer wrap and asynchronous reset with tags in flight.
module tb_xbar_resp_router;

  logic        clk;
  logic        rst;
  logic        req_fire;
  logic        req_master;
  logic        req_cmd;
  logic        slave_resp;
  logic [31:0] slave_rdata;
  logic        resp0;
  logic        resp1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        stall;
  logic [2:0]  outstanding;
  logic        proto_err;

  int nChecks = 0;
  int nFails  = 0;

  xbar_resp_router #(
    .DEPTH  (4),
    .DATA_W (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_fire    (req_fire),
    .req_master  (req_master),
    .req_cmd     (req_cmd),
    .slave_resp  (slave_resp),
    .slave_rdata (slave_rdata),
    .resp0       (resp0),
    .resp1       (resp1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .stall       (stall),
    .outstanding (outstanding),
    .proto_err   (proto_err)
  );

  // Free-running 10 ns clock; stimulus changes and checks happen on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic fire, input logic m, input logic cmd,
                               input logic rsp, input logic [31:0] data);
    req_fire    = fire;
    req_master  = m;
    req_cmd     = cmd;
    slave_resp  = rsp;
    slave_rdata = data;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyReset();
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #3;
    nChecks++;
    if ({resp0, resp1, stall, proto_err} !== 4'b0000) begin
      nFails++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {resp0, resp1, stall, proto_err});
    end
    nChecks++;
    if (outstanding !== 3'd0) begin
      nFails++;
      $display("[TB] FAIL reset_outstanding: got %0d expected 0", outstanding);
    end
    nChecks++;
    if ({rdata0, rdata1} !== 64'h0) begin
      nFails++;
      $display("[TB] FAIL reset_rdata: got %h expected 0", {rdata0, rdata1});
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_in_order();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    nChecks++;
    if (outstanding !== 3'd1) begin
      nFails++;
      $display("[TB] FAIL inorder_occ1: got %0d expected 1", outstanding);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    nChecks++;
    if (outstanding !== 3'd3) begin
      nFails++;
      $display("[TB] FAIL inorder_occ3: got %0d expected 3", outstanding);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0F0F0F0F);
    tick();
    nChecks++;
    if ({resp0, resp1, rdata0} !== {2'b10, 32'h0F0F0F0F}) begin
      nFails++;
      $display("[TB] FAIL inorder_r1: got %b/%h expected 10/0f0f0f0f", {resp0, resp1}, rdata0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
    tick();
    nChecks++;
    if ({resp0, resp1, rdata1, rdata0} !== {2'b01, 32'h0, 32'h0F0F0F0F}) begin
      nFails++;
      $display("[TB] FAIL inorder_r2: got %b/%h/%h expected 01/00000000/0f0f0f0f",
               {resp0, resp1}, rdata1, rdata0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h00F0F0F0);
    tick();
    nChecks++;
    if ({resp0, resp1, rdata0, rdata1} !== {2'b10, 32'h00F0F0F0, 32'h0}) begin
      nFails++;
      $display("[TB] FAIL inorder_r3: got %b/%h/%h expected 10/00f0f0f0/00000000",
               {resp0, resp1}, rdata0, rdata1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    nChecks++;
    if ({resp0, resp1, proto_err, outstanding} !== {3'b000, 3'd0}) begin
      nFails++;
      $display("[TB] FAIL inorder_idle: got resp=%b err=%b occ=%0d expected 00/0/0",
               {resp0, resp1}, proto_err, outstanding);
    end
  endtask

  task automatic test_fill_full();
    applyReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, logic'(i % 2), 1'b0, 1'b0, 32'h0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    nChecks++;
    if ({outstanding, stall, proto_err} !== {3'd4, 1'b1, 1'b0}) begin
      nFails++;
      $display("[TB] FAIL full_state: got occ=%0d stall=%b err=%b expected 4/1/0",
               outstanding, stall, proto_err);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    nChecks++;
    if ({outstanding, stall, proto_err} !== {3'd4, 1'b1, 1'b1}) begin
      nFails++;
      $display("[TB] FAIL full_overflow: got occ=%0d stall=%b err=%b expected 4/1/1",
               outstanding, stall, proto_err);
    end
  endtask

  task automatic test_push_pop_full();
    logic        fillM [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        fillC [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        expM  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        expC  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [31:0] d;
    applyReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fillM[i], fillC[i], 1'b0, 32'h0);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hAAAA5555);
    tick();
    nChecks++;
    if ({resp0, resp1, rdata0} !== {2'b10, 32'hAAAA5555}) begin
      nFails++;
      $display("[TB] FAIL fullpp_resp: got %b/%h expected 10/aaaa5555", {resp0, resp1}, rdata0);
    end
    nChecks++;
    if ({outstanding, stall, proto_err} !== {3'd4, 1'b1, 1'b0}) begin
      nFails++;
      $display("[TB] FAIL fullpp_state: got occ=%0d stall=%b err=%b expected 4/1/0",
               outstanding, stall, proto_err);
    end
    exp0 = 32'hAAAA5555;
    exp1 = 32'h0;
    for (int k = 0; k < 4; k++) begin
      d = 32'hD0000000 + 32'(k);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, d);
      tick();
      if (expM[k]) exp1 = expC[k] ? 32'h0 : d;
      else         exp0 = expC[k] ? 32'h0 : d;
      nChecks++;
      if ({resp0, resp1, rdata0, rdata1} !== {~expM[k], expM[k], exp0, exp1}) begin
        nFails++;
        $display("[TB] FAIL fullpp_drain%0d: got %b/%h/%h expected %b/%h/%h", k,
                 {resp0, resp1}, rdata0, rdata1, {~expM[k], expM[k]}, exp0, exp1);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    nChecks++;
    if ({outstanding, proto_err} !== {3'd0, 1'b0}) begin
      nFails++;
      $display("[TB] FAIL fullpp_end: got occ=%0d err=%b expected 0/0", outstanding, proto_err);
    end
  endtask

  task automatic test_empty_resp();
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    tick();
    nChecks++;
    if ({resp0, resp1, proto_err, outstanding} !== {3'b001, 3'd1}) begin
      nFails++;
      $display("[TB] FAIL empty_resp: got resp=%b err=%b occ=%0d expected 00/1/1",
               {resp0, resp1}, proto_err, outstanding);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678);
    tick();
    nChecks++;
    if ({resp0, resp1, rdata1, outstanding} !== {2'b01, 32'h12345678, 3'd0}) begin
      nFails++;
      $display("[TB] FAIL empty_follow: got %b/%h occ=%0d expected 01/12345678 occ=0",
               {resp0, resp1}, rdata1, outstanding);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [31:0] d;
    logic        jm;
    logic        jc;
    applyReset();
    exp0 = 32'h0;
    exp1 = 32'h0;
    for (int i = 0; i <= 10; i++) begin
      jm = ((i - 1) % 3 == 1);
      jc = ((i - 1) % 4 == 3);
      d  = 32'h10000000 + 32'(i - 1) * 32'h111;
      applyStimulus(i < 10, (i % 3 == 1), (i % 4 == 3), i > 0, d);
      tick();
      if (i > 0) begin
        if (jm) exp1 = jc ? 32'h0 : d;
        else    exp0 = jc ? 32'h0 : d;
        nChecks++;
        if ({resp0, resp1, rdata0, rdata1} !== {~jm, jm, exp0, exp1}) begin
          nFails++;
          $display("[TB] FAIL wrap_resp%0d: got %b/%h/%h expected %b/%h/%h", i - 1,
                   {resp0, resp1}, rdata0, rdata1, {~jm, jm}, exp0, exp1);
        end
        nChecks++;
        if (outstanding !== ((i < 10) ? 3'd1 : 3'd0)) begin
          nFails++;
          $display("[TB] FAIL wrap_occ%0d: got %0d expected %0d", i - 1, outstanding,
                   (i < 10) ? 1 : 0);
        end
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    nChecks++;
    if ({resp0, resp1, proto_err} !== 3'b000) begin
      nFails++;
      $display("[TB] FAIL wrap_tail: got resp=%b err=%b expected 00/0", {resp0, resp1}, proto_err);
    end
  endtask

  task automatic test_reset_midflight();
    logic fillM [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic fillC [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    applyReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fillM[i], fillC[i], 1'b0, 32'h0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h5A5A5A5A);
    tick();
    nChecks++;
    if ({resp0, resp1, rdata0, outstanding} !== {2'b10, 32'h5A5A5A5A, 3'd3}) begin
      nFails++;
      $display("[TB] FAIL mid_pre: got %b/%h occ=%0d expected 10/5a5a5a5a occ=3",
               {resp0, resp1}, rdata0, outstanding);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    nChecks++;
    if ({resp0, resp1, stall, proto_err, outstanding} !== {4'b0000, 3'd0}) begin
      nFails++;
      $display("[TB] FAIL mid_async: got resp=%b stall=%b err=%b occ=%0d expected all 0",
               {resp0, resp1}, stall, proto_err, outstanding);
    end
    nChecks++;
    if ({rdata0, rdata1} !== 64'h0) begin
      nFails++;
      $display("[TB] FAIL mid_rdata: got %h expected 0", {rdata0, rdata1});
    end
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hC0DE0000 + 32'(k));
      tick();
      nChecks++;
      if ({resp0, resp1, proto_err, outstanding, rdata0} !== {3'b001, 3'd0, 32'h0}) begin
        nFails++;
        $display("[TB] FAIL mid_after%0d: got resp=%b err=%b occ=%0d rdata0=%h expected 00/1/0/0",
                 k, {resp0, resp1}, proto_err, outstanding, rdata0);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Scenario sequence; each task leaves the inputs idle for the next one.
  initial begin
    test_reset();
    test_in_order();
    test_fill_full();
    test_push_pop_full();
    test_empty_resp();
    test_back_to_back();
    test_reset_midflight();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
